// File: rtl/pwm_rgb_capture.sv
// Recovers per-channel PWM duty codes from three sampled waveforms by counting high samples per PERIOD-cycle window.
// Define PWM_RGB_CAPTURE_STABLE_EN to publish only results that repeat across two consecutive windows.
module pwm_rgb_capture #(
  parameter int PERIOD      = 3,
  parameter int DUTY_W      = 2,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk_pwm,
  input  logic                  rst,
  input  logic                  led_r,
  input  logic                  led_g,
  input  logic                  led_b,
  output logic [3*DUTY_W-1:0]   rgb_pwm,
  output logic                  valid,
  output logic                  changed,
  output logic                  locked
);

  localparam int WCNT_W   = (PERIOD > 2) ? $clog2(PERIOD) : 1;
  localparam int ACC_W    = $clog2(PERIOD + 1);
  localparam int CODE_MAX = (1 << DUTY_W) - 1;
  localparam int OUT_W    = 3 * DUTY_W;

  typedef enum logic {SKIP, RUN} state_t;

  logic [2:0]        led_in;
  logic [WCNT_W-1:0] wcnt_q, wcnt_d;
  logic              close;
  logic [OUT_W-1:0]  codes;

  state_t            state_q, state_d;
  logic [OUT_W-1:0]  rgb_q, rgb_d;
  logic              valid_q, valid_d;
  logic              changed_q, changed_d;
  logic              locked_q, locked_d;
  logic              publish;

`ifdef PWM_RGB_CAPTURE_STABLE_EN
  logic [OUT_W-1:0]  cand_q, cand_d;
  logic              match_q, match_d;
`endif

  assign led_in = {led_r, led_g, led_b};
  assign close  = (wcnt_q == WCNT_W'(PERIOD - 1));
  assign wcnt_d = close ? '0 : wcnt_q + 1'b1;

  // Channel index 2 is red so that codes packs as {r,g,b}.
  for (genvar gi = 0; gi < 3; gi++) begin : g_chan
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [ACC_W-1:0]       acc_q, acc_d;
    logic [ACC_W-1:0]       total;
    logic                   sample;
    logic [DUTY_W-1:0]      code;

    always_comb begin
      sync_d = {sync_q[SYNC_STAGES-2:0], led_in[gi]};
      sample = sync_q[SYNC_STAGES-1];
      total  = acc_q + ACC_W'(sample);
      acc_d  = close ? '0 : total;
      if (int'(total) > CODE_MAX) begin
        code = DUTY_W'(CODE_MAX);
      end else begin
        code = DUTY_W'(total);
      end
    end

    always_ff @(posedge clk_pwm or posedge rst) begin
      if (rst) begin
        sync_q <= '0;
        acc_q  <= '0;
      end else begin
        sync_q <= sync_d;
        acc_q  <= acc_d;
      end
    end

    assign codes[gi*DUTY_W +: DUTY_W] = code;
  end

  always_comb begin
    state_d   = state_q;
    rgb_d     = rgb_q;
    valid_d   = 1'b0;
    changed_d = 1'b0;
    locked_d  = locked_q;
    publish   = 1'b0;
`ifdef PWM_RGB_CAPTURE_STABLE_EN
    cand_d    = cand_q;
    match_d   = match_q;
`endif
    case (state_q)
      SKIP: begin
        // First window still contains the synchroniser's reset zeros.
        if (close) state_d = RUN;
      end
      RUN: begin
        if (close) begin
`ifdef PWM_RGB_CAPTURE_STABLE_EN
          publish = match_q && (codes == cand_q);
          cand_d  = codes;
          match_d = 1'b1;
`else
          publish = 1'b1;
`endif
        end
      end
      default: state_d = SKIP;
    endcase
    if (publish) begin
      rgb_d     = codes;
      valid_d   = 1'b1;
      changed_d = (codes != rgb_q);
      locked_d  = 1'b1;
    end
  end

  always_ff @(posedge clk_pwm or posedge rst) begin
    if (rst) begin
      wcnt_q    <= '0;
      state_q   <= SKIP;
      rgb_q     <= '0;
      valid_q   <= 1'b0;
      changed_q <= 1'b0;
      locked_q  <= 1'b0;
`ifdef PWM_RGB_CAPTURE_STABLE_EN
      cand_q    <= '0;
      match_q   <= 1'b0;
`endif
    end else begin
      wcnt_q    <= wcnt_d;
      state_q   <= state_d;
      rgb_q     <= rgb_d;
      valid_q   <= valid_d;
      changed_q <= changed_d;
      locked_q  <= locked_d;
`ifdef PWM_RGB_CAPTURE_STABLE_EN
      cand_q    <= cand_d;
      match_q   <= match_d;
`endif
    end
  end

  assign rgb_pwm = rgb_q;
  assign valid   = valid_q;
  assign changed = changed_q;
  assign locked  = locked_q;

endmodule

// File: doc/pwm_rgb_capture.md
Name: pwm_rgb_capture

Overview:
- Receive-side counterpart of the RGB PWM driver: samples three PWM waveforms (red, green, blue) and recovers the 2-bit duty code per channel as a packed 6-bit word.
- Counts high samples over a fixed window equal to the PWM period. For a periodic input the result does not depend on phase alignment.
- Used for loop-back self-test of the light-stick LED path and for reading PWM from an external controller.

Parameters:
- PERIOD, 3: PWM period in clk_pwm cycles; sets window length (legal 2..255).
- DUTY_W, 2: bits per recovered channel code; packed output width is 3*DUTY_W.
- SYNC_STAGES, 2: input synchroniser depth (legal 2..3).

Ports:
- clk_pwm  in   1            sample clock, rising edge
- rst      in   1            asynchronous reset, active-high
- led_r    in   1            red PWM waveform (async to clk_pwm allowed)
- led_g    in   1            green PWM waveform
- led_b    in   1            blue PWM waveform
- rgb_pwm  out  3*DUTY_W     recovered codes {r,g,b}, r in MSBs (default [5:4]=r, [3:2]=g, [1:0]=b)
- valid    out  1            one-cycle pulse when rgb_pwm is updated
- changed  out  1            one-cycle pulse, coincident with valid, when the new rgb_pwm differs from the previous value
- locked   out  1            high once at least one window has been published since reset

Behaviour:
- Reset (async assert, sync release): rgb_pwm=0, valid=0, changed=0, locked=0, synchroniser flops=0, window counter wcnt=0, accumulators=0, FSM=SKIP.
- Synchroniser: each input passes through SYNC_STAGES flops. Accumulators see only synchronised samples.
- Window counter: wcnt runs 0..PERIOD-1 and wraps to 0, free-running in all states. Its width is clog2(PERIOD), minimum 1.
- Accumulator, per channel, width clog2(PERIOD+1):
  - On every edge: acc <= (wcnt==PERIOD-1) ? 0 : acc + sample.
  - Window total = acc + sample at the closing edge (wcnt==PERIOD-1).
- Clamp: total > 2^DUTY_W-1 becomes 2^DUTY_W-1. With the default parameters there is no clamp; totals 0..3 map directly to codes 0..3.
- FSM, two states:
  - SKIP: the first closed window after reset is discarded, because the synchroniser is still flushing reset zeros. No output update. At its closing edge go to RUN.
  - RUN: at every closing edge, register the clamped codes into rgb_pwm and set valid=1 for the following cycle. changed=1 when the new value != the old rgb_pwm. locked is set at the first RUN publish and held until rst.
- Latency: an input edge reaches the accumulator after SYNC_STAGES cycles. A window result appears on rgb_pwm one cycle after its closing edge.
- valid cadence: exactly one pulse every PERIOD cycles in RUN. valid is never high for two consecutive cycles when PERIOD>=2.
- Input constant high: code = min(PERIOD, 2^DUTY_W-1). Input constant low: code 0.
- Reset mid-window: all partial accumulation is lost, FSM returns to SKIP, locked drops immediately (async).
- Channels are fully independent. Simultaneous edges on all three inputs need no special handling.

Optional Feature:
- Macro: PWM_RGB_CAPTURE_STABLE_EN.
- Defined:
  - Adds a candidate register (3*DUTY_W bits) and a match flag.
  - A window result is published only if it equals the immediately preceding window result. Otherwise it is stored as the new candidate with no valid.
  - The first RUN window always becomes the candidate only, so locked asserts at the end of the second matching window.
  - valid and changed fire only on publish.
  - Candidate and match flag are reset by rst.
- Undefined: every RUN window publishes as described in Behaviour, and no candidate register exists.

Test Plan:
- Reset, all inputs held 0 -> first valid at window 2 (SKIP discards window 1), rgb_pwm=6'b000000, locked=1, changed=0.
- Driver model with code 6'b10_01_11 (r high 2 of 3, g 1 of 3, b 3 of 3), arbitrary phase -> every valid shows 6'b100111. changed pulses once only, on the first publish.
- Switch the driver from 6'b100111 to 6'b011000 mid-window -> at most one transitional value, then steady 6'b011000. changed pulses on each value change; valid spacing is exactly 3 cycles throughout.
- PERIOD=7, DUTY_W=2, led_r held 1, g/b 0 -> r clamps to 2'b11, rgb_pwm=6'b110000.
- Assert rst for 1 cycle mid-window while locked -> outputs 0 asynchronously. Next valid comes only after one discarded window, with correct value.
- STABLE_EN defined, alternate the driver code each window between 6'b000001 and 6'b000010 -> no valid, locked stays 0. Hold 6'b000010 -> publish after two matching windows.
